// File: rtl/board_init_ctrl_if.sv
// Wishbone-style board memory bus used by board_init_ctrl.
// The master drives address/data/strobe; the slave (board memory) returns read data and ACK.
interface board_init_ctrl_if;
  logic [7:0] ADR_O;
  logic [7:0] DAT_O;
  logic [7:0] DAT_I;
  logic       WE_O;
  logic       CYC_O;
  logic       STB_O;
  logic       ACK_I;

  modport master (
    output ADR_O, DAT_O, WE_O, CYC_O, STB_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, WE_O, CYC_O, STB_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/board_init_ctrl.sv
// board_init_ctrl: builds a new game board in a 16x16 board memory (addr {row,col}).
// On start it clears the active R x C area, places mines from a Galois LFSR, then
// writes each cell's neighbour mine count into mine_ind (field bits [4:1]).
// Every bus transfer is ISSUE (held until ACK) followed by a one-cycle GAP.
// Optional feature macro: SAFE_START_EN adds safe_row/safe_col; mines are kept out of
// the 3x3 area around that cell and the mine target is capped at R*C-9.
module board_init_ctrl #(
  parameter int          MAX_DIM    = 16,
  parameter logic [15:0] LFSR_SEED0 = 16'hACE1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start,
  input  logic [4:0]  cfg_rows,
  input  logic [4:0]  cfg_cols,
  input  logic [7:0]  cfg_mines,
  input  logic [15:0] seed,
`ifdef SAFE_START_EN
  input  logic [3:0]  safe_row,
  input  logic [3:0]  safe_col,
`endif
  output logic        busy,
  output logic        done,
  board_init_ctrl_if.master wb
);

  localparam logic [4:0]  DIM  = 5'(MAX_DIM);
  localparam logic [15:0] POLY = 16'hB400;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_WR, S_CLR_GAP,
    S_PL_GEN, S_PL_RD, S_PL_RGAP, S_PL_WR, S_PL_WGAP,
    S_CN_NB, S_CN_NRD, S_CN_NGAP, S_CN_CRD, S_CN_CGAP, S_CN_WR, S_CN_WGAP,
    S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [4:0]  r_rows, w_rows_next;
  logic [4:0]  r_cols, w_cols_next;
  logic [7:0]  r_n, w_n_next;
  logic [7:0]  r_placed, w_placed_next;
  logic [15:0] r_lfsr, w_lfsr_next;
  logic [3:0]  r_row, w_row_next;
  logic [3:0]  r_col, w_col_next;
  logic [3:0]  r_nb, w_nb_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [7:0]  r_adr, w_adr_next;
  logic [7:0]  r_dat, w_dat_next;
  logic        r_we, w_we_next;
  logic [7:0]  r_rdat, w_rdat_next;

  // Start-time configuration: clamp dimensions and derive the mine target.
  logic [4:0]  w_rows_in, w_cols_in;
  logic [9:0]  w_area, w_cap;
  logic [7:0]  w_n_in;

  assign w_rows_in = (cfg_rows == 5'd0 || cfg_rows > DIM) ? DIM : cfg_rows;
  assign w_cols_in = (cfg_cols == 5'd0 || cfg_cols > DIM) ? DIM : cfg_cols;
  assign w_area    = {5'd0, w_rows_in} * {5'd0, w_cols_in};
`ifdef SAFE_START_EN
  assign w_cap     = (w_area > 10'd9) ? (w_area - 10'd9) : 10'd0;
`else
  assign w_cap     = w_area - 10'd1;
`endif
  assign w_n_in    = ({2'b00, cfg_mines} < w_cap) ? cfg_mines : w_cap[7:0];

  // Row-major walk over the active area.
  logic       w_col_wrap, w_last_cell;
  logic [3:0] w_adv_row, w_adv_col;

  assign w_col_wrap  = ({1'b0, r_col} == r_cols - 5'd1);
  assign w_last_cell = w_col_wrap && ({1'b0, r_row} == r_rows - 5'd1);
  assign w_adv_row   = w_col_wrap ? r_row + 4'd1 : r_row;
  assign w_adv_col   = w_col_wrap ? 4'd0 : r_col + 4'd1;

  // Mine candidate from the LFSR value after one Galois step.
  logic [15:0] w_lfsr_step;
  logic        w_cand_safe, w_cand_ok;

  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? POLY : 16'h0000);

`ifdef SAFE_START_EN
  logic [3:0] r_safe_row, r_safe_col;
  logic [4:0] w_cr, w_cc, w_sr, w_sc;

  assign w_cr = {1'b0, w_lfsr_step[7:4]};
  assign w_cc = {1'b0, w_lfsr_step[3:0]};
  assign w_sr = {1'b0, r_safe_row};
  assign w_sc = {1'b0, r_safe_col};
  assign w_cand_safe = (w_cr + 5'd1 >= w_sr) && (w_cr <= w_sr + 5'd1) &&
                       (w_cc + 5'd1 >= w_sc) && (w_cc <= w_sc + 5'd1);

  // Safe cell is captured only when a new board is started.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_safe_row <= 4'd0;
      r_safe_col <= 4'd0;
    end else if (r_state == S_IDLE && start) begin
      r_safe_row <= safe_row;
      r_safe_col <= safe_col;
    end
  end
`else
  assign w_cand_safe = 1'b0;
`endif

  assign w_cand_ok = ({1'b0, w_lfsr_step[7:4]} < r_rows) &&
                     ({1'b0, w_lfsr_step[3:0]} < r_cols) && !w_cand_safe;

  // Neighbour addresses in scan order NW,N,NE,W,E,SW,S,SE; -1 wraps to 63 and fails the range test.
  logic [5:0] w_nb_row [8];
  logic [5:0] w_nb_col [8];
  logic [7:0] w_nb_adr [8];
  logic [7:0] w_nb_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nb
      localparam logic [5:0] DR = (gi < 3) ? 6'h3F : ((gi < 5) ? 6'h00 : 6'h01);
      localparam logic [5:0] DC = (gi == 0 || gi == 3 || gi == 5) ? 6'h3F :
                                  ((gi == 1 || gi == 6) ? 6'h00 : 6'h01);
      assign w_nb_row[gi] = {2'b00, r_row} + DR;
      assign w_nb_col[gi] = {2'b00, r_col} + DC;
      assign w_nb_ok[gi]  = (w_nb_row[gi] < {1'b0, r_rows}) && (w_nb_col[gi] < {1'b0, r_cols});
      assign w_nb_adr[gi] = {w_nb_row[gi][3:0], w_nb_col[gi][3:0]};
    end
  endgenerate

  // Bus and status outputs follow the registered state; address/data are stable for a whole ISSUE.
  logic w_issue;

  assign w_issue  = (r_state == S_CLR_WR) || (r_state == S_PL_RD) || (r_state == S_PL_WR) ||
                    (r_state == S_CN_NRD) || (r_state == S_CN_CRD) || (r_state == S_CN_WR);
  assign wb.CYC_O = w_issue;
  assign wb.STB_O = w_issue;
  assign wb.ADR_O = r_adr;
  assign wb.DAT_O = r_dat;
  assign wb.WE_O  = r_we;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= S_IDLE;
      r_rows   <= 5'd0;
      r_cols   <= 5'd0;
      r_n      <= 8'd0;
      r_placed <= 8'd0;
      r_lfsr   <= LFSR_SEED0;
      r_row    <= 4'd0;
      r_col    <= 4'd0;
      r_nb     <= 4'd0;
      r_cnt    <= 4'd0;
      r_adr    <= 8'd0;
      r_dat    <= 8'd0;
      r_we     <= 1'b0;
      r_rdat   <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_rows   <= w_rows_next;
      r_cols   <= w_cols_next;
      r_n      <= w_n_next;
      r_placed <= w_placed_next;
      r_lfsr   <= w_lfsr_next;
      r_row    <= w_row_next;
      r_col    <= w_col_next;
      r_nb     <= w_nb_next;
      r_cnt    <= w_cnt_next;
      r_adr    <= w_adr_next;
      r_dat    <= w_dat_next;
      r_we     <= w_we_next;
      r_rdat   <= w_rdat_next;
    end
  end

  // Phase sequencing: CLEAR -> PLACE -> COUNT, each bus transfer followed by a GAP state.
  always_comb begin
    w_state_next  = r_state;
    w_rows_next   = r_rows;
    w_cols_next   = r_cols;
    w_n_next      = r_n;
    w_placed_next = r_placed;
    w_lfsr_next   = r_lfsr;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_nb_next     = r_nb;
    w_cnt_next    = r_cnt;
    w_adr_next    = r_adr;
    w_dat_next    = r_dat;
    w_we_next     = r_we;
    w_rdat_next   = r_rdat;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rows_next   = w_rows_in;
          w_cols_next   = w_cols_in;
          w_n_next      = w_n_in;
          w_placed_next = 8'd0;
          w_lfsr_next   = (seed == 16'h0000) ? LFSR_SEED0 : seed;
          w_row_next    = 4'd0;
          w_col_next    = 4'd0;
          w_adr_next    = 8'h00;
          w_dat_next    = 8'h00;
          w_we_next     = 1'b1;
          w_state_next  = S_CLR_WR;
        end
      end
      S_CLR_WR: if (wb.ACK_I) w_state_next = S_CLR_GAP;
      S_CLR_GAP: begin
        if (w_last_cell) begin
          w_row_next = 4'd0;
          w_col_next = 4'd0;
          w_nb_next  = 4'd0;
          w_cnt_next = 4'd0;
          w_state_next = (r_n == 8'd0) ? S_CN_NB : S_PL_GEN;
        end else begin
          w_row_next   = w_adv_row;
          w_col_next   = w_adv_col;
          w_adr_next   = {w_adv_row, w_adv_col};
          w_state_next = S_CLR_WR;
        end
      end
      S_PL_GEN: begin
        w_lfsr_next = w_lfsr_step;
        if (w_cand_ok) begin
          w_adr_next   = w_lfsr_step[7:0];
          w_we_next    = 1'b0;
          w_state_next = S_PL_RD;
        end
      end
      S_PL_RD: begin
        if (wb.ACK_I) begin
          w_rdat_next  = wb.DAT_I;
          w_state_next = S_PL_RGAP;
        end
      end
      S_PL_RGAP: begin
        if (r_rdat[7]) begin
          w_state_next = S_PL_GEN;
        end else begin
          w_dat_next   = r_rdat | 8'h80;
          w_we_next    = 1'b1;
          w_state_next = S_PL_WR;
        end
      end
      S_PL_WR: begin
        if (wb.ACK_I) begin
          w_placed_next = r_placed + 8'd1;
          w_state_next  = S_PL_WGAP;
        end
      end
      S_PL_WGAP: begin
        if (r_placed == r_n) begin
          w_row_next   = 4'd0;
          w_col_next   = 4'd0;
          w_nb_next    = 4'd0;
          w_cnt_next   = 4'd0;
          w_state_next = S_CN_NB;
        end else begin
          w_state_next = S_PL_GEN;
        end
      end
      S_CN_NB: begin
        if (r_nb[3]) begin
          w_adr_next   = {r_row, r_col};
          w_we_next    = 1'b0;
          w_state_next = S_CN_CRD;
        end else if (w_nb_ok[r_nb[2:0]]) begin
          w_adr_next   = w_nb_adr[r_nb[2:0]];
          w_we_next    = 1'b0;
          w_state_next = S_CN_NRD;
        end else begin
          w_nb_next = r_nb + 4'd1;
        end
      end
      S_CN_NRD: begin
        if (wb.ACK_I) begin
          w_cnt_next   = r_cnt + {3'b000, wb.DAT_I[7]};
          w_state_next = S_CN_NGAP;
        end
      end
      S_CN_NGAP: begin
        w_nb_next    = r_nb + 4'd1;
        w_state_next = S_CN_NB;
      end
      S_CN_CRD: begin
        if (wb.ACK_I) begin
          w_rdat_next  = wb.DAT_I;
          w_state_next = S_CN_CGAP;
        end
      end
      S_CN_CGAP: begin
        w_dat_next   = {r_rdat[7:5], r_cnt, r_rdat[0]};
        w_we_next    = 1'b1;
        w_state_next = S_CN_WR;
      end
      S_CN_WR: if (wb.ACK_I) w_state_next = S_CN_WGAP;
      S_CN_WGAP: begin
        if (w_last_cell) begin
          w_state_next = S_DONE;
        end else begin
          w_row_next   = w_adv_row;
          w_col_next   = w_adv_col;
          w_nb_next    = 4'd0;
          w_cnt_next   = 4'd0;
          w_state_next = S_CN_NB;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_init_ctrl.sv
// Directed bench for board_init_ctrl: board memory slave with optional wait states and
// stray ACKs, plus a behavioural board builder that produces the expected memory image.
module tb_board_init_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_rows = 5'd0;
  logic [4:0]  cfg_cols = 5'd0;
  logic [7:0]  cfg_mines = 8'd0;
  logic [15:0] seed = 16'd0;
  logic        busy, done;
`ifdef SAFE_START_EN
  logic [3:0]  safe_row = 4'd0;
  logic [3:0]  safe_col = 4'd0;
`endif

  board_init_ctrl_if wb();

  board_init_ctrl dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .start     (start),
    .cfg_rows  (cfg_rows),
    .cfg_cols  (cfg_cols),
    .cfg_mines (cfg_mines),
    .seed      (seed),
`ifdef SAFE_START_EN
    .safe_row  (safe_row),
    .safe_col  (safe_col),
`endif
    .busy      (busy),
    .done      (done),
    .wb        (wb)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  bit         fill_req = 1'b0;
  logic [7:0] fill_val = 8'h00;
  bit         rand_waits = 1'b0;
  bit         stray_en = 1'b0;
  int         wr_cnt = 0;
  int         s_st = 0;
  int         s_wait = 0;

  task automatic s_ack();
    wb.ACK_I <= 1'b1;
    wb.DAT_I <= mem[wb.ADR_O];
    if (wb.WE_O) begin
      mem[wb.ADR_O] <= wb.DAT_O;
      wr_cnt <= wr_cnt + 1;
    end
    s_st <= 2;
  endtask

  // Board memory slave
  always @(posedge CLK_I) begin
    if (fill_req) for (int i = 0; i < 256; i++) mem[i] <= fill_val;
    if (RST_I) begin
      s_st <= 0;
      wb.ACK_I <= 1'b0;
      wb.DAT_I <= 8'h00;
    end else begin
      case (s_st)
        0: if (wb.CYC_O && wb.STB_O) begin
             if (!rand_waits || $urandom_range(0, 3) == 0) s_ack();
             else begin s_wait <= $urandom_range(0, 2); s_st <= 1; end
           end
        1: if (!(wb.CYC_O && wb.STB_O)) s_st <= 0;
           else if (s_wait == 0) s_ack();
           else s_wait <= s_wait - 1;
        2: if (stray_en && $urandom_range(0, 1) == 1) begin
             wb.ACK_I <= 1'b1; s_st <= 3;
           end else begin
             wb.ACK_I <= 1'b0; s_st <= 0;
           end
        default: begin wb.ACK_I <= 1'b0; s_st <= 0; end
      endcase
    end
  end

  task automatic fill_mem(input logic [7:0] v);
    @(negedge CLK_I); fill_val = v; fill_req = 1'b1;
    @(negedge CLK_I); fill_req = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] r, input logic [4:0] c, input logic [7:0] m,
                          input logic [15:0] sd);
    @(negedge CLK_I);
    cfg_rows = r; cfg_cols = c; cfg_mines = m; seed = sd; start = 1'b1;
    @(negedge CLK_I);
    start = 1'b0;
  endtask

  // Runs until done; reports busy anomalies, done pulses seen and whether the budget expired.
  task automatic wait_done(input int budget, output int busy_bad, output int dones,
                           output bit timeout);
    busy_bad = 0; dones = 0; timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK_I);
      if (done === 1'b1) begin
        dones++;
        if (busy !== 1'b0) busy_bad++;
        timeout = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    if (!timeout) repeat (4) begin
      @(negedge CLK_I);
      if (done === 1'b1) dones++;
    end
  endtask

  // Expected board built straight from the algorithm description, starting from current memory.
  task automatic model_run(input int r, input int c, input int m, input logic [15:0] sd);
    int rows, cols, n, placed, cnt, nr, nc, cr, cc;
    logic [15:0] lf;
    bit lsb;
    rows = (r == 0 || r > 16) ? 16 : r;
    cols = (c == 0 || c > 16) ? 16 : c;
    for (int i = 0; i < 256; i++) gold[i] = mem[i];
    for (int rr = 0; rr < rows; rr++)
      for (int cl = 0; cl < cols; cl++) gold[rr*16+cl] = 8'h00;
    n = rows * cols - 1;
    if (m < n) n = m;
    lf = (sd == 16'h0000) ? 16'hACE1 : sd;
    placed = 0;
    while (placed < n) begin
      lsb = lf[0];
      lf = lf >> 1;
      if (lsb) lf = lf ^ 16'hB400;
      cr = int'(lf[7:4]);
      cc = int'(lf[3:0]);
      if (cr < rows && cc < cols && gold[cr*16+cc][7] == 1'b0) begin
        gold[cr*16+cc] = gold[cr*16+cc] | 8'h80;
        placed++;
      end
    end
    for (int rr = 0; rr < rows; rr++)
      for (int cl = 0; cl < cols; cl++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            nr = rr + dr; nc = cl + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < rows && nc >= 0 && nc < cols)
              if (gold[nr*16+nc][7]) cnt++;
          end
        gold[rr*16+cl] = {gold[rr*16+cl][7:5], cnt[3:0], gold[rr*16+cl][0]};
      end
  endtask

  function automatic int mines_in(input int rows, input int cols);
    int k = 0;
    for (int rr = 0; rr < rows; rr++)
      for (int cl = 0; cl < cols; cl++) if (mem[rr*16+cl][7]) k++;
    return k;
  endfunction

  function automatic int board_diff(output int first);
    int bad = 0;
    first = 0;
    for (int i = 255; i >= 0; i--) if (mem[i] !== gold[i]) begin bad++; first = i; end
    return bad;
  endfunction

  task automatic test_reset();
    int act;
    repeat (2) @(posedge CLK_I);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if ({wb.CYC_O, wb.STB_O, wb.WE_O} !== 3'b000) begin
      n_fail++; $display("FAIL reset_cyc_stb_we: got %b want 000", {wb.CYC_O, wb.STB_O, wb.WE_O}); end
    n_checks++; if ({wb.ADR_O, wb.DAT_O} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_adr_dat: got %h want 0000", {wb.ADR_O, wb.DAT_O}); end
    @(negedge CLK_I);
    cfg_rows = 5'd4; cfg_cols = 5'd4; cfg_mines = 8'd2; seed = 16'h1234; start = 1'b1;
    @(negedge CLK_I);
    start = 1'b0; RST_I = 1'b0;
    act = 0;
    repeat (10) begin @(negedge CLK_I); if (wb.CYC_O !== 1'b0 || busy !== 1'b0) act++; end
    n_checks++; if (act !== 0) begin n_fail++; $display("FAIL start_in_reset: active cycles %0d want 0", act); end
    $display("test_reset: done");
  endtask

  task automatic test_clear_only();
    int bb, dn, first, bad, w0, nz; bit to;
    fill_mem(8'hFF);
    model_run(0, 20, 0, 16'h0001);
    w0 = wr_cnt;
    do_start(5'd0, 5'd20, 8'd0, 16'h0001);
    wait_done(30000, bb, dn, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL clear_timeout: no done got 0 want 1"); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL clear_done_pulses: got %0d want 1", dn); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL clear_busy: bad cycles %0d want 0", bb); end
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h00) nz++;
    n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL clear_all_zero: nonzero cells %0d want 0", nz); end
    bad = board_diff(first);
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL clear_board: %0d diffs, addr %0d got %h want %h", bad, first, mem[first], gold[first]); end
    n_checks++; if (wr_cnt - w0 !== 512) begin n_fail++; $display("FAIL clear_writes: got %0d want 512", wr_cnt - w0); end
    $display("test_clear_only: writes=%0d", wr_cnt - w0);
  endtask

  task automatic test_small_3x3();
    int bb, dn, first, bad, w0, cbad, cnt; bit to;
    fill_mem(8'h3C);
    model_run(3, 3, 1, 16'h1234);
    w0 = wr_cnt;
    do_start(5'd3, 5'd3, 8'd1, 16'h1234);
    wait_done(5000, bb, dn, to);
    n_checks++; if (to || dn !== 1) begin n_fail++; $display("FAIL small_done: pulses %0d want 1", dn); end
    n_checks++; if (mines_in(3, 3) !== 1) begin n_fail++; $display("FAIL small_mines: got %0d want 1", mines_in(3, 3)); end
    cbad = 0;
    for (int rr = 0; rr < 3; rr++)
      for (int cl = 0; cl < 3; cl++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && rr+dr >= 0 && rr+dr < 3 && cl+dc >= 0 && cl+dc < 3)
              if (mem[(rr+dr)*16 + cl+dc][7]) cnt++;
        if (int'(mem[rr*16+cl][4:1]) != cnt) cbad++;
      end
    n_checks++; if (cbad !== 0) begin n_fail++; $display("FAIL small_counts: bad cells %0d want 0", cbad); end
    bad = board_diff(first);
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL small_board: %0d diffs, addr %0d got %h want %h", bad, first, mem[first], gold[first]); end
    n_checks++; if (wr_cnt - w0 !== 19) begin n_fail++; $display("FAIL small_writes: got %0d want 19", wr_cnt - w0); end
    $display("test_small_3x3: mines=%0d", mines_in(3, 3));
  endtask

  task automatic test_full_4x4();
    int bb, dn, first, bad, clr, expc; bit to;
    logic [3:0] got;
    fill_mem(8'h00);
    model_run(4, 4, 255, 16'h00F0);
    do_start(5'd4, 5'd4, 8'd255, 16'h00F0);
    wait_done(20000, bb, dn, to);
    n_checks++; if (to || dn !== 1) begin n_fail++; $display("FAIL full_done: pulses %0d want 1", dn); end
    n_checks++; if (mines_in(4, 4) !== 15) begin n_fail++; $display("FAIL full_mines: got %0d want 15", mines_in(4, 4)); end
    clr = 0;
    for (int i = 0; i < 16; i++) if (!mem[(i/4)*16 + i%4][7]) clr = (i/4)*16 + i%4;
    expc = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && clr/16+dr >= 0 && clr/16+dr < 4 && clr%16+dc >= 0 && clr%16+dc < 4) expc++;
    got = mem[clr][4:1];
    n_checks++; if (int'(got) != expc) begin n_fail++; $display("FAIL full_clear_cell: addr %0d got %0d want %0d", clr, got, expc); end
    bad = board_diff(first);
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL full_board: %0d diffs, addr %0d got %h want %h", bad, first, mem[first], gold[first]); end
    $display("test_full_4x4: clear cell %0d ind=%0d", clr, got);
  endtask

  task automatic test_one_by_one();
    int bb, dn, first, bad, w0; bit to;
    fill_mem(8'hFF);
    w0 = wr_cnt;
    do_start(5'd1, 5'd1, 8'd5, 16'h0001);
    wait_done(1000, bb, dn, to);
    n_checks++; if (to || dn !== 1) begin n_fail++; $display("FAIL one_done: pulses %0d want 1", dn); end
    n_checks++; if (mem[0] !== 8'h00) begin n_fail++; $display("FAIL one_cell: got %h want 00", mem[0]); end
    n_checks++; if (mem[1] !== 8'hFF || mem[16] !== 8'hFF) begin n_fail++;
      $display("FAIL one_outside: got %h %h want ff ff", mem[1], mem[16]); end
    n_checks++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL one_writes: got %0d want 2", wr_cnt - w0); end
    fill_mem(8'h42);
    model_run(1, 5, 2, 16'h7777);
    do_start(5'd1, 5'd5, 8'd2, 16'h7777);
    wait_done(5000, bb, dn, to);
    bad = board_diff(first);
    n_checks++; if (to || bad !== 0) begin n_fail++;
      $display("FAIL row_board: %0d diffs, addr %0d got %h want %h", bad, first, mem[first], gold[first]); end
    $display("test_one_by_one: cell0=%h", mem[0]);
  endtask

  task automatic test_reset_mid_count();
    int bb, dn, first, bad, w0; bit to, ok;
    fill_mem(8'h00);
    w0 = wr_cnt;
    do_start(5'd4, 5'd4, 8'd3, 16'h1234);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK_I);
      if (wr_cnt - w0 >= 21) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_reach_count: writes %0d want >=21", wr_cnt - w0); end
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    n_checks++; if ({wb.CYC_O, wb.STB_O, busy} !== 3'b000) begin n_fail++;
      $display("FAIL midreset_idle: cyc/stb/busy got %b want 000", {wb.CYC_O, wb.STB_O, busy}); end
    @(negedge CLK_I); RST_I = 1'b0;
    fill_mem(8'h11);
    model_run(16, 16, 40, 16'hBEEF);
    do_start(5'd16, 5'd16, 8'd40, 16'hBEEF);
    wait_done(30000, bb, dn, to);
    n_checks++; if (to || dn !== 1) begin n_fail++; $display("FAIL midreset_done: pulses %0d want 1", dn); end
    n_checks++; if (mines_in(16, 16) !== 40) begin n_fail++; $display("FAIL midreset_mines: got %0d want 40", mines_in(16, 16)); end
    bad = board_diff(first);
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL midreset_board: %0d diffs, addr %0d got %h want %h", bad, first, mem[first], gold[first]); end
    $display("test_reset_mid_count: mines=%0d", mines_in(16, 16));
  endtask

  task automatic test_back_to_back();
    int bb, dn, first, bad, w0; bit to;
    rand_waits = 1'b1; stray_en = 1'b1;
    fill_mem(8'hA5);
    model_run(7, 11, 12, 16'h0000);
    w0 = wr_cnt;
    do_start(5'd7, 5'd11, 8'd12, 16'h0000);
    repeat (300) @(negedge CLK_I);
    cfg_rows = 5'd16; cfg_cols = 5'd16; cfg_mines = 8'd99; seed = 16'h0005; start = 1'b1;
    @(negedge CLK_I); start = 1'b0;
    wait_done(30000, bb, dn, to);
    n_checks++; if (to || dn !== 1) begin n_fail++; $display("FAIL b2b_done: pulses %0d want 1", dn); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL b2b_busy: bad cycles %0d want 0", bb); end
    n_checks++; if (wr_cnt - w0 !== 166) begin n_fail++; $display("FAIL b2b_writes: got %0d want 166", wr_cnt - w0); end
    n_checks++; if (mines_in(7, 11) !== 12) begin n_fail++; $display("FAIL b2b_mines: got %0d want 12", mines_in(7, 11)); end
    bad = board_diff(first);
    n_checks++; if (bad !== 0) begin n_fail++;
      $display("FAIL b2b_board: %0d diffs, addr %0d got %h want %h", bad, first, mem[first], gold[first]); end
    n_checks++; if (wb.CYC_O !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle_after: cyc/busy got %b%b want 00", wb.CYC_O, busy); end
    rand_waits = 1'b0; stray_en = 1'b0;
    $display("test_back_to_back: writes=%0d", wr_cnt - w0);
  endtask

  initial begin
    test_reset();
    test_clear_only();
    test_small_3x3();
    test_full_4x4();
    test_one_by_one();
    test_reset_mid_count();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
